// File: rtl/mips_run_monitor.sv
`default_nettype none
// ============================================================================
// mips_run_monitor : gates CPU execution for a cycle budget / PC breakpoint,
//                    then streams final PC state and the register file out.
// Revision: 1.0
// ============================================================================
module mips_run_monitor #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int NREGS   = 32,
  parameter int CYCLE_W = 32,
  parameter int IDX_W   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CYCLE_W-1:0] max_cycles,
  input  logic [PC_W-1:0]    halt_pc,
  input  logic               halt_on_pc_en,
  input  logic [PC_W-1:0]    pc,
  output logic               cpu_run,
  output logic [IDX_W-1:0]   rf_addr,
  input  logic [DATA_W-1:0]  rf_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [IDX_W-1:0]   dump_idx,
  output logic [DATA_W-1:0]  dump_data,
  output logic [PC_W-1:0]    final_pc,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [1:0]         halt_cause,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DUMP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(NREGS - 1);
  localparam logic [IDX_W-1:0]   C_IDX_ONE  = IDX_W'(1);
  localparam logic [CYCLE_W-1:0] C_CYC_ONE  = CYCLE_W'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [CYCLE_W-1:0] r_max_cycles;
  logic [PC_W-1:0]    r_halt_pc;
  logic               r_halt_en;
  logic [CYCLE_W-1:0] r_cycle_count;
  logic [PC_W-1:0]    r_final_pc;
  logic [1:0]         r_halt_cause;
  logic [IDX_W-1:0]   r_idx;

  logic w_bp_hit;
  logic w_budget_out;
  logic w_run;
  logic w_start_acc;
  logic w_dump_fire;

  assign w_bp_hit     = r_halt_en && (pc == r_halt_pc);
  assign w_budget_out = (r_cycle_count == r_max_cycles);
  // Combinational so the instruction sitting at the breakpoint never issues.
  assign w_run        = (r_state == S_RUN) && !w_bp_hit && !w_budget_out;
  assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_dump_fire  = (r_state == S_DUMP) && dump_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)                                 w_next_state = S_RUN;
      S_RUN:          if (!w_run)                                w_next_state = S_DUMP;
      S_DUMP:         if (dump_ready && (r_idx == C_LAST_IDX))   w_next_state = S_DONE;
      default:                                                   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_run    = w_run;
    busy       = (r_state == S_RUN) || (r_state == S_DUMP);
    done       = (r_state == S_DONE);
    dump_valid = (r_state == S_DUMP);
    rf_addr    = (r_state == S_DUMP) ? r_idx : '0;
    dump_idx   = rf_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_cycles  <= '0;
      r_halt_pc     <= '0;
      r_halt_en     <= 1'b0;
      r_cycle_count <= '0;
      r_final_pc    <= '0;
      r_halt_cause  <= 2'b00;
      r_idx         <= '0;
    end else if (w_start_acc) begin
      r_max_cycles  <= max_cycles;
      r_halt_pc     <= halt_pc;
      r_halt_en     <= halt_on_pc_en;
      r_cycle_count <= '0;
      r_halt_cause  <= 2'b00;
      r_idx         <= '0;
    end else if (r_state == S_RUN) begin
      if (w_run) begin
        r_cycle_count <= r_cycle_count + C_CYC_ONE;
      end else begin
        r_final_pc   <= pc;
        r_halt_cause <= {w_bp_hit, w_budget_out};
      end
    end else if (w_dump_fire && (r_idx != C_LAST_IDX)) begin
      r_idx <= r_idx + C_IDX_ONE;
    end
  end

  assign dump_data   = rf_data;
  assign final_pc    = r_final_pc;
  assign cycle_count = r_cycle_count;
  assign halt_cause  = r_halt_cause;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_monitor.sv
`default_nettype none
// ============================================================================
// tb_mips_run_monitor : randomized bench with a toy CPU and a run/dump model.
// Revision: 1.0
// ============================================================================
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] max_cycles = '0;
  logic [31:0] halt_pc = '0;
  logic        halt_on_pc_en = 1'b0;
  logic [31:0] pc;
  logic        cpu_run;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic [31:0] final_pc;
  logic [31:0] cycle_count;
  logic [1:0]  halt_cause;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  // Toy CPU: every enabled cycle pc advances by 4 and one register is written.
  logic [31:0] regs [32];
  logic [31:0] exp_regs [32];
  logic        load_req = 1'b0;
  logic [31:0] load_pc = '0;
  logic [31:0] cpu_pc = '0;

  assign pc      = cpu_pc;
  assign rf_data = regs[rf_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) begin
      cpu_pc <= load_pc;
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : $urandom;
    end else if (cpu_run) begin
      cpu_pc <= cpu_pc + 32'd4;
      regs[1 + ((cpu_pc >> 2) % 31)] <= cpu_pc ^ 32'hA5A5_0000;
    end
  end

  mips_run_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycles(max_cycles),
    .halt_pc(halt_pc), .halt_on_pc_en(halt_on_pc_en), .pc(pc),
    .cpu_run(cpu_run), .rf_addr(rf_addr), .rf_data(rf_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .final_pc(final_pc), .cycle_count(cycle_count),
    .halt_cause(halt_cause), .busy(busy), .done(done)
  );

  task automatic check_reset_vals(input string tag);
    logic [31:0] got;
    logic [31:0] want;
    got = {cpu_run, dump_valid, rf_addr, dump_idx, halt_cause, busy, done};
    want = '0;
    tests++;
    if (got !== want) begin
      fails++; $display("FAIL %s_ctrl: got %0h want %0h", tag, got, want);
    end
    tests++;
    if (final_pc !== 32'h0 || cycle_count !== 32'h0) begin
      fails++; $display("FAIL %s_regs: got pc=%0h cnt=%0h want 0 0", tag, final_pc, cycle_count);
    end
    tests++;
    if (dump_data !== regs[0]) begin
      fails++; $display("FAIL %s_data: got %0h want %0h", tag, dump_data, regs[0]);
    end
  endtask

  // mode: 0 ready high, 1 pattern 1,0,0,1, 2 random. stop_at < 32 leaves mid-dump.
  task automatic do_run(input logic [31:0] p0, input logic [31:0] n, input logic [31:0] hpc,
                        input bit en, input int mode, input bit sdr, input int stop_at);
    logic [31:0] diff, k, exp_cnt, a, exp_pc;
    logic [1:0]  exp_cause;
    bit          bp, rdy;
    int          guard, runs, nexp, cyc;
    @(negedge clk); load_pc = p0; load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    for (int i = 0; i < 32; i++) exp_regs[i] = regs[i];
    diff      = hpc - p0;
    k         = diff >> 2;
    bp        = en && (diff[1:0] == 2'b00) && (k <= n);
    exp_cnt   = bp ? k : n;
    exp_cause = {bp, exp_cnt == n};
    exp_pc    = p0 + 32'd4 * exp_cnt;
    for (int i = 0; i < int'(exp_cnt); i++) begin
      a = p0 + 32'(4 * i);
      exp_regs[1 + ((a >> 2) % 31)] = a ^ 32'hA5A5_0000;
    end
    max_cycles = n; halt_pc = hpc; halt_on_pc_en = en; start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL run_entry: got busy=%b done=%b want 1 0", busy, done);
    end
    guard = 0; runs = 0;
    while (dump_valid !== 1'b1 && guard < 2000) begin
      if (cpu_run === 1'b1) runs++;
      start = sdr && (guard == 1);
      if (start) begin
        max_cycles = 32'd0; halt_pc = cpu_pc; halt_on_pc_en = 1'b1;
      end
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (guard != int'(exp_cnt) + 1) begin
      fails++; $display("FAIL run_len: got %0d cycles want %0d", guard, exp_cnt + 1);
    end
    tests++;
    if (runs != int'(exp_cnt) || cycle_count !== exp_cnt) begin
      fails++; $display("FAIL run_count: got runs=%0d cnt=%0d want %0d", runs, cycle_count, exp_cnt);
    end
    tests++;
    if (halt_cause !== exp_cause) begin
      fails++; $display("FAIL halt_cause: got %b want %b", halt_cause, exp_cause);
    end
    tests++;
    if (final_pc !== exp_pc) begin
      fails++; $display("FAIL final_pc: got %0h want %0h", final_pc, exp_pc);
    end
    nexp = 0; cyc = 0;
    while (nexp < 32 && cyc < 500) begin
      if (nexp == stop_at) return;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'($urandom_range(0, 1));
      dump_ready = rdy;
      tests++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'(nexp) || dump_data !== exp_regs[nexp]) begin
        fails++;
        $display("FAIL dump_word: got v=%b idx=%0d data=%0h want v=1 idx=%0d data=%0h",
                 dump_valid, dump_idx, dump_data, nexp, exp_regs[nexp]);
      end
      if (rdy) nexp++;
      cyc++;
      @(negedge clk);
    end
    dump_ready = 1'b0;
    tests++;
    if (nexp != 32 || (mode == 0 && cyc != 32)) begin
      fails++; $display("FAIL dump_len: got words=%0d cycles=%0d want 32", nexp, cyc);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0) begin
      fails++; $display("FAIL done_state: got done=%b busy=%b v=%b want 1 0 0", done, busy, dump_valid);
    end
    tests++;
    if (cycle_count !== exp_cnt || final_pc !== exp_pc || halt_cause !== exp_cause) begin
      fails++; $display("FAIL done_hold: got cnt=%0d pc=%0h cause=%b want %0d %0h %b",
                        cycle_count, final_pc, halt_cause, exp_cnt, exp_pc, exp_cause);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_budget();
    do_run(32'h0000_0100, 32'd5, 32'h0, 1'b0, 0, 1'b0, 32);
  endtask

  task automatic test_breakpoint();
    do_run(32'h0000_0000, 32'd1000, 32'h0000_003C, 1'b1, 0, 1'b0, 32);
  endtask

  task automatic test_simultaneous();
    do_run(32'h0000_0200, 32'd9, 32'h0000_0224, 1'b1, 0, 1'b0, 32);
  endtask

  task automatic test_backpressure();
    do_run(32'h0000_0040, 32'd12, 32'h0, 1'b0, 1, 1'b0, 32);
  endtask

  task automatic test_zero_budget();
    do_run(32'h0000_0080, 32'd0, 32'h0000_0080, 1'b0, 0, 1'b0, 32);
  endtask

  task automatic test_bp_at_entry();
    do_run(32'h0000_0300, 32'd20, 32'h0000_0300, 1'b1, 2, 1'b0, 32);
  endtask

  task automatic test_reset_mid_dump();
    do_run(32'h0000_0400, 32'd7, 32'h0, 1'b0, 1, 1'b0, 7);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_dump_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_run(32'h0000_0500, 32'd10, 32'h0, 1'b0, 0, 1'b1, 32);
  endtask

  task automatic test_random();
    logic [31:0] p0, n, hpc;
    for (int t = 0; t < 8; t++) begin
      p0  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      n   = 32'($urandom_range(0, 40));
      hpc = ($urandom_range(0, 3) == 0) ? $urandom : p0 + 32'(4 * $urandom_range(0, 45));
      do_run(p0, n, hpc, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 32);
    end
  endtask

  initial begin
    test_reset();
    test_budget();
    test_breakpoint();
    test_simultaneous();
    test_backpressure();
    test_zero_budget();
    test_bp_at_entry();
    test_reset_mid_dump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_run_monitor.md
# mips_run_monitor

Synthesizable run-control and state-dump unit for the MIPS core. It gates CPU execution for a programmable cycle budget, optionally stopping when the PC reaches a breakpoint address. After the halt it streams the final PC and every register-file entry out over a valid/ready port. It sits between the CPU top level and a host or bench.

## Interface
Parameters:
- DATA_W, 32, register-file word width
- PC_W, 32, program-counter width
- NREGS, 32, number of registers dumped (power of two, ≥2)
- CYCLE_W, 32, width of cycle budget/counter
- IDX_W, $clog2(NREGS), register index width (derived)

Ports:
- clk  in  1  rising-edge clock shared with the CPU
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a run; ignored unless state is IDLE or DONE
- max_cycles  in  CYCLE_W  run budget in CPU clock-enable cycles; sampled at start
- halt_pc  in  PC_W  breakpoint address; sampled at start
- halt_on_pc_en  in  1  breakpoint enable; sampled at start
- pc  in  PC_W  live CPU program counter
- cpu_run  out  1  CPU clock enable / advance strobe
- rf_addr  out  IDX_W  register-file read address (async read port on CPU)
- rf_data  in  DATA_W  register-file read data for rf_addr
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts dump word
- dump_idx  out  IDX_W  index of current dump word
- dump_data  out  DATA_W  current dump word (= rf_data)
- final_pc  out  PC_W  PC captured at halt
- cycle_count  out  CYCLE_W  enabled cycles executed in last/current run
- halt_cause  out  2  bit0 = budget exhausted, bit1 = breakpoint hit
- busy  out  1  state is RUN or DUMP
- done  out  1  state is DONE

## Operation
- States: IDLE, RUN, DUMP, DONE. Reset → IDLE.
- IDLE/DONE + start: latch max_cycles, halt_pc, halt_on_pc_en; clear cycle_count, halt_cause, idx; go RUN.
- RUN: bp_hit = halt_on_pc_en_q && (pc == halt_pc_q); budget_out = (cycle_count == max_cycles_q).
- cpu_run = (state == RUN) && !bp_hit && !budget_out (combinational, so the instruction at halt_pc is never executed).
- RUN, cpu_run=1: cycle_count += 1 each edge.
- RUN, cpu_run=0: capture final_pc = pc, halt_cause = {bp_hit, budget_out} (both bits may be set); go DUMP.
- DUMP: rf_addr = idx; dump_valid = 1; dump_idx = idx; dump_data = rf_data. On dump_valid && dump_ready: if idx == NREGS-1 go DONE, else idx += 1.
- dump_data/dump_idx stay stable while valid && !ready (CPU is halted, idx unchanged).
- DONE: final_pc, cycle_count, halt_cause hold until the next start.
- start while busy: ignored, no effect on any state.
- cycle_count never wraps: the run stops at max_cycles ≤ 2^CYCLE_W−1.
- max_cycles = 0: one RUN cycle with cpu_run=0, halt_cause=01, cycle_count=0.
- rf_addr = 0 outside DUMP.

## Timing
- Reset values: cpu_run 0, dump_valid 0, dump_idx 0, dump_data follows rf_data[0], rf_addr 0, final_pc 0, cycle_count 0, halt_cause 00, busy 0, done 0.
- rst_n low mid-run or mid-dump: immediate return to IDLE with the reset values above. Partial dump is discarded.
- start sampled at edge E0 → RUN from E0. cpu_run high for the next N = max_cycles cycles, absent a breakpoint. DUMP entered at edge E0+N+1.
- Breakpoint: cpu_run drops in the same cycle pc equals halt_pc_q. If pc == halt_pc_q at run entry, zero instructions execute.
- Dump with dump_ready tied high: NREGS cycles. DONE at edge (DUMP entry + NREGS).
- done rises the cycle after the last handshake and falls the cycle after an accepted start.

## Test plan
- Budget halt: max_cycles=5, breakpoint disabled → cpu_run high exactly 5 cycles, cycle_count=5, halt_cause=01, final_pc = PC after 5 advances.
- Breakpoint: factorial program, halt_pc=0x0000003C, max_cycles=1000 → cpu_run low when pc=0x3C, final_pc=0x3C, halt_cause=10, cycle_count = instructions executed before 0x3C.
- Simultaneous: pc reaches halt_pc on the exact cycle cycle_count==max_cycles → halt_cause=11.
- Backpressure: dump_ready toggled 1,0,0,1… → 32 words with dump_idx 0..31 in order, no duplicates or skips, dump_data stable while stalled, dump_data for idx 0 = 0.
- max_cycles=0 → cpu_run never high, halt_cause=01, 32-word dump of reset register contents, done=1.
- Reset mid-dump at idx 7, then start again → all outputs at reset values after rst_n low. The second run dumps from idx 0. A start pulsed during RUN has no effect.
